// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader
//   Polls two serial 8-bit temperature sensors (geothermal, room) over a
//   shared SCLK/SDI bus with separate active-low chip selects. Both readings
//   and the room>geothermal flag are updated together once per conversion,
//   marked by a one-cycle sample_valid_o strobe. Conversions start either
//   periodically (every SAMPLE_PERIOD clk cycles) or from a start_i pulse.
//
//   Optional build macro: SENSOR_PARITY_EN
//     defined   -> 9-bit frames (8 data MSB first + even parity bit); a bad
//                  frame from either sensor rejects both readings and pulses
//                  parity_err_o instead of sample_valid_o.
//     undefined -> 8-bit frames, parity_err_o tied to 0.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   start_i                one-cycle request for an immediate conversion
//   sdi_i                  serial data from the selected sensor, MSB first
//   sclk_o                 serial clock, idles low
//   cs_geo_n_o, cs_room_n_o  sensor selects, active low, never both low
//   geothermal_o, room_temp_o  last accepted readings (unsigned)
//   temp_g_geothermal_o    room_temp_o > geothermal_o, registered
//   sample_valid_o         one-cycle pulse when the readings update
//   busy_o                 high from the first setup cycle through UPDATE
//   parity_err_o           one-cycle pulse on a rejected conversion
module temp_sensor_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       sdi_i,
  output logic       sclk_o,
  output logic       cs_geo_n_o,
  output logic       cs_room_n_o,
  output logic [7:0] geothermal_o,
  output logic [7:0] room_temp_o,
  output logic       temp_g_geothermal_o,
  output logic       sample_valid_o,
  output logic       busy_o,
  output logic       parity_err_o
);

`ifdef SENSOR_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE, GEO_SETUP, GEO_SHIFT, GAP, ROOM_SETUP, ROOM_SHIFT, UPDATE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      div_q, div_d;     // clk count inside one CLK_DIV phase
  logic            half_q, half_d;   // 0: sclk high half, 1: sclk low half
  logic [3:0]      bit_q, bit_d;     // bit index within the frame
  logic [PW-1:0]   per_q;
  logic [NB-1:0]   geo_sr_q, room_sr_q;
  logic [7:0]      geo_q, room_q;
  logic            gt_q, sv_q;

  logic wrap, div_last, sclk_d, sclk_rise, conv_done, frames_ok;

  assign wrap     = (per_q == PW'(SAMPLE_PERIOD - 1));
  assign div_last = (div_q == 8'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        // start and wrap on the same cycle collapse into one conversion
        if (start_i || wrap) begin
          state_d = GEO_SETUP;
          div_d   = '0;
        end
      end
      GEO_SETUP, ROOM_SETUP: begin
        if (div_last) begin
          state_d = (state_q == GEO_SETUP) ? GEO_SHIFT : ROOM_SHIFT;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GEO_SHIFT, ROOM_SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_q == 4'(NB - 1))
              state_d = (state_q == GEO_SHIFT) ? GAP : UPDATE;
            else
              bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (div_last) begin
          state_d = ROOM_SETUP;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus pins decode straight from registered state, so reset/abort takes
  // effect on the very next edge.
  assign sclk_o      = ((state_q == GEO_SHIFT) || (state_q == ROOM_SHIFT)) && !half_q;
  assign cs_geo_n_o  = !((state_q == GEO_SETUP) || (state_q == GEO_SHIFT));
  assign cs_room_n_o = !((state_q == ROOM_SETUP) || (state_q == ROOM_SHIFT));
  assign busy_o      = (state_q != IDLE);

  // sdi is captured on the clk edge that raises sclk.
  assign sclk_d    = ((state_d == GEO_SHIFT) || (state_d == ROOM_SHIFT)) && !half_d;
  assign sclk_rise = sclk_d && !sclk_o;
  assign conv_done = (state_q == ROOM_SHIFT) && (state_d == UPDATE);

`ifdef SENSOR_PARITY_EN
  logic pe_q;
  assign frames_ok    = !(^geo_sr_q) && !(^room_sr_q);
  assign parity_err_o = pe_q;
  always_ff @(posedge clk) begin
    if (rst) pe_q <= 1'b0;
    else     pe_q <= conv_done && !frames_ok;
  end
`else
  assign frames_ok    = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      half_q    <= 1'b0;
      bit_q     <= '0;
      per_q     <= '0;
      geo_sr_q  <= '0;
      room_sr_q <= '0;
      geo_q     <= '0;
      room_q    <= '0;
      gt_q      <= 1'b0;
      sv_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      per_q   <= wrap ? '0 : per_q + PW'(1);
      if (sclk_rise && (state_d == GEO_SHIFT))
        geo_sr_q <= {geo_sr_q[NB-2:0], sdi_i};
      if (sclk_rise && (state_d == ROOM_SHIFT))
        room_sr_q <= {room_sr_q[NB-2:0], sdi_i};
      // Load on the edge into UPDATE so the strobe sits in the UPDATE cycle;
      // the flag uses only the two fresh readings.
      sv_q <= conv_done && frames_ok;
      if (conv_done && frames_ok) begin
        geo_q  <= geo_sr_q[NB-1 -: 8];
        room_q <= room_sr_q[NB-1 -: 8];
        gt_q   <= (room_sr_q[NB-1 -: 8] > geo_sr_q[NB-1 -: 8]);
      end
    end
  end

  assign geothermal_o        = geo_q;
  assign room_temp_o         = room_q;
  assign temp_g_geothermal_o = gt_q;
  assign sample_valid_o      = sv_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench for temp_sensor_reader (CLK_DIV=4, SAMPLE_PERIOD=300).
// A behavioural sensor pair shifts frames out on sclk; a negedge monitor
// tallies bus timing, strobes and busy cycles; directed conversions are
// checked against hand-computed readings.
module tb_temp_sensor_reader;
  localparam int CD = 4;
  localparam int SP = 300;
`ifdef SENSOR_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int CONV_LEN = 2*CD*(1+2*NB) + CD + 1;

  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, sdi_i;
  logic sclk_o, cs_geo_n_o, cs_room_n_o, temp_g_geothermal_o;
  logic sample_valid_o, busy_o, parity_err_o;
  logic [7:0] geothermal_o, room_temp_o;

  always #5 clk = ~clk;

  temp_sensor_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .sdi_i(sdi_i),
    .sclk_o(sclk_o), .cs_geo_n_o(cs_geo_n_o), .cs_room_n_o(cs_room_n_o),
    .geothermal_o(geothermal_o), .room_temp_o(room_temp_o),
    .temp_g_geothermal_o(temp_g_geothermal_o),
    .sample_valid_o(sample_valid_o), .busy_o(busy_o),
    .parity_err_o(parity_err_o)
  );

  int n_vec = 0, n_err = 0;

  // Sensor model: bit index restarts when a select falls, advances on sclk rise.
  logic [NB-1:0] geo_frame = '0, room_frame = '0;
  int idx = 0;
  always @(negedge cs_geo_n_o or negedge cs_room_n_o or posedge sclk_o)
    if (sclk_o) idx = idx + 1;
    else        idx = 0;
  always @* begin
    sdi_i = 1'b0;
    if (idx < NB) begin
      if (!cs_geo_n_o)       sdi_i = geo_frame[NB-1-idx];
      else if (!cs_room_n_o) sdi_i = room_frame[NB-1-idx];
    end
  end

  // Monitor, sampled on the inactive edge.
  int sv_cnt = 0, pe_cnt = 0, busy_cyc = 0, ovl_cnt = 0, idle_sclk = 0;
  int bad_run = 0, bad_win = 0, windows = 0, rises = 0, run = 0;
  int gap = 0, last_gap = 0;
  logic [7:0] sv_geo = '0, sv_room = '0;
  logic p_cs_low = 1'b0, p_sclk = 1'b0, p_geo_low = 1'b0, gapping = 1'b0, cs_low;
  always @(negedge clk) begin
    cs_low = !cs_geo_n_o || !cs_room_n_o;
    if (!cs_geo_n_o && !cs_room_n_o) ovl_cnt++;
    if (sclk_o && !cs_low) idle_sclk++;
    if (busy_o) busy_cyc++;
    if (parity_err_o) pe_cnt++;
    if (sample_valid_o) begin
      sv_cnt++; sv_geo = geothermal_o; sv_room = room_temp_o;
    end
    if (cs_low) begin
      if (p_cs_low && (sclk_o == p_sclk)) run++;
      else begin
        if (p_cs_low && run != CD) bad_run++;
        run = 1;
      end
      if (sclk_o && !p_sclk) rises++;
    end else if (p_cs_low) begin
      if (run != CD) bad_run++;
      if (rises != NB) bad_win++;
      rises = 0;
      windows++;
    end
    if (p_geo_low && cs_geo_n_o) begin gapping = 1'b1; gap = 0; end
    if (gapping && cs_geo_n_o && cs_room_n_o) gap++;
    if (gapping && !cs_room_n_o) begin last_gap = gap; gapping = 1'b0; end
    p_cs_low = cs_low; p_sclk = sclk_o; p_geo_low = !cs_geo_n_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data byte followed (in parity builds) by its even-parity bit, optionally flipped.
  function automatic logic [NB-1:0] mk(input logic [7:0] d, input logic bad);
    logic [8:0] f;
    f = {d, (^d) ^ bad};
    return f[8 -: NB];
  endfunction

  task automatic run_conv(input logic [7:0] g, input logic [7:0] r, input logic bad,
                          input logic [7:0] eg, input logic [7:0] er, input logic ef,
                          input int esv, input int epe);
    int b0, s0, p0, w0;
    geo_frame = mk(g, 1'b0);
    room_frame = mk(r, bad);
    b0 = busy_cyc; s0 = sv_cnt; p0 = pe_cnt; w0 = windows;
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    for (int i = 0; i < CONV_LEN + 20 && busy_o; i++) @(negedge clk);
    chk("busy_done", busy_o, 0);
    chk("busy_len", busy_cyc - b0, CONV_LEN);
    chk("cs_windows", windows - w0, 2);
    chk("sv_count", sv_cnt - s0, esv);
    chk("perr_count", pe_cnt - p0, epe);
    chk("geothermal", geothermal_o, eg);
    chk("room_temp", room_temp_o, er);
    chk("room_gt_geo", temp_g_geothermal_o, ef);
    if (esv == 1) begin
      chk("sv_geo", sv_geo, eg);
      chk("sv_room", sv_room, er);
    end
  endtask

  initial begin
    time t1, t2;
    int s0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk_o, 0);
    chk("rst_cs_geo", cs_geo_n_o, 1);
    chk("rst_cs_room", cs_room_n_o, 1);
    chk("rst_geo", geothermal_o, 0);
    chk("rst_room", room_temp_o, 0);
    chk("rst_gt", temp_g_geothermal_o, 0);
    chk("rst_sv", sample_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_perr", parity_err_o, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_conv(8'h3C, 8'h50, 1'b0, 8'h3C, 8'h50, 1'b1, 1, 0);
    run_conv(8'h64, 8'h64, 1'b0, 8'h64, 8'h64, 1'b0, 1, 0);
    run_conv(8'h00, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1, 0);
    run_conv(8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 1, 0);

    chk("sclk_phase_len", bad_run, 0);
    chk("rises_per_win", bad_win, 0);
    chk("cs_gap", last_gap, CD);
    chk("cs_overlap", ovl_cnt, 0);
    chk("sclk_idle", idle_sclk, 0);

    // Autonomous polling; a start mid-conversion must be ignored.
    for (int i = 0; i < SP + CONV_LEN && !busy_o; i++) @(negedge clk);
    chk("auto_start1", busy_o, 1);
    t1 = $time; s0 = sv_cnt;
    repeat (50) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    for (int i = 0; i < 2*SP && busy_o; i++) @(negedge clk);
    for (int i = 0; i < 2*SP && !busy_o; i++) @(negedge clk);
    chk("auto_start2", busy_o, 1);
    t2 = $time;
    chk("auto_period", 32'((t2 - t1) / 10), SP);
    chk("auto_sv", sv_cnt - s0, 1);
    for (int i = 0; i < CONV_LEN + 20 && busy_o; i++) @(negedge clk);
    chk("auto_done", busy_o, 0);

    // Reset in the middle of the room frame.
    geo_frame = mk(8'h20, 1'b0);
    room_frame = mk(8'h11, 1'b0);
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    for (int i = 0; i < CONV_LEN && cs_room_n_o; i++) @(negedge clk);
    chk("room_sel", cs_room_n_o, 0);
    repeat (12) @(negedge clk);
    rst = 1'b1; s0 = sv_cnt;
    @(negedge clk);
    chk("abort_cs_geo", cs_geo_n_o, 1);
    chk("abort_cs_room", cs_room_n_o, 1);
    chk("abort_sclk", sclk_o, 0);
    chk("abort_geo", geothermal_o, 0);
    chk("abort_room", room_temp_o, 0);
    chk("abort_gt", temp_g_geothermal_o, 0);
    chk("abort_busy", busy_o, 0);
    rst = 1'b0;
    repeat (CONV_LEN) @(negedge clk);
    chk("abort_sv", sv_cnt - s0, 0);
    run_conv(8'h20, 8'h11, 1'b0, 8'h20, 8'h11, 1'b0, 1, 0);

`ifdef SENSOR_PARITY_EN
    run_conv(8'h3C, 8'h50, 1'b1, 8'h20, 8'h11, 1'b0, 0, 1);
`else
    chk("perr_tied", pe_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/temp_sensor_reader.md
Name: temp_sensor_reader

Overview:
- Front end that produces the temperature inputs consumed by the temperature controller: geothermal reading, room reading, and the room-warmer-than-ground flag.
- Polls two serial 8-bit temperature sensors over a shared SCLK/SDI bus with separate active-low chip selects.
- Presents both readings atomically, with a one-cycle valid strobe, each conversion.
- Conversions run periodically, or on demand via a start pulse.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
- SAMPLE_PERIOD, 1000: clk cycles between automatic conversion starts; must exceed one conversion length (see Behaviour).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse requesting an immediate conversion
- sdi  input  1  serial data from the selected sensor, MSB first
- sclk  output  1  serial clock; idles low
- cs_geo_n  output  1  geothermal sensor select, active low
- cs_room_n  output  1  room sensor select, active low
- geothermal  output  8  last accepted geothermal reading (unsigned)
- room_temp  output  8  last accepted room reading (unsigned)
- temp_g_geothermal  output  1  1 when room_temp > geothermal (strict), registered
- sample_valid  output  1  one-cycle pulse when the readings update
- busy  output  1  high while a conversion is in progress
- parity_err  output  1  one-cycle pulse on a rejected frame; constant 0 without the macro

Behaviour:
- Reset values: sclk=0, cs_geo_n=1, cs_room_n=1, geothermal=0, room_temp=0, temp_g_geothermal=0, sample_valid=0, busy=0, parity_err=0, period counter=0, state=IDLE.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - At the wrap, a conversion starts if state is IDLE; otherwise that tick is dropped, not queued.
- start pulse: starts a conversion if IDLE; ignored while busy. A start coincident with the wrap counts as a single conversion.
- State machine: IDLE -> GEO_SETUP -> GEO_SHIFT -> GAP -> ROOM_SETUP -> ROOM_SHIFT -> UPDATE -> IDLE.
- SETUP states:
  - The selected cs_n is driven low on the first cycle.
  - sclk is held low for CLK_DIV cycles.
- SHIFT states, per bit (N = 8, or 9 with the macro):
  - sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - sdi is sampled into the shift register on the clk edge where sclk goes 0->1; MSB first.
- After the last bit's low half, cs_n returns high.
- Time with cs low per sensor: CLK_DIV*(1+2N) cycles.
- GAP: both cs_n high for CLK_DIV cycles. cs_geo_n and cs_room_n are never low simultaneously.
- UPDATE (1 cycle):
  - Register geothermal, room_temp and temp_g_geothermal together.
  - Pulse sample_valid for 1 cycle, coincident with the new values.
  - Return to IDLE.
- busy: high from the first SETUP cycle through the UPDATE cycle inclusive.
- Conversion length: 2*CLK_DIV*(1+2N) + CLK_DIV + 1 clk cycles. Defaults: 141 cycles (N=8), 157 cycles (N=9).
- Outputs hold their values between conversions. temp_g_geothermal is computed from the two new readings only, never from a mix of old and new.
- Comparison is unsigned 8-bit; equal values give 0.
- rst mid-conversion:
  - Aborts the conversion; all outputs take their reset values on the next edge.
  - Partial data is discarded and no sample_valid is issued.

Optional Feature:
- Macro: SENSOR_PARITY_EN.
- Defined:
  - Each frame is 9 bits: 8 data bits MSB first, then an even-parity bit (XOR of all 9 bits must be 0).
  - If either frame fails the check, UPDATE leaves all readings unchanged, suppresses sample_valid, and pulses parity_err for 1 cycle in UPDATE.
  - Both readings are rejected together.
- Undefined:
  - Frames are 8 bits, with no check.
  - parity_err is tied to 0.

Test Plan:
- Reset, then start at cycle 5 with geo sensor returning 0x3C and room sensor returning 0x50 -> busy for 141 cycles; sample_valid pulses once; geothermal=0x3C, room_temp=0x50, temp_g_geothermal=1.
- Equal readings 0x64/0x64 -> temp_g_geothermal=0. Room 0xFF, geo 0x00 -> 1. Room 0x00, geo 0xFF -> 0.
- SCLK timing with CLK_DIV=4:
  - Exactly 8 rising edges per cs-low window.
  - sclk high/low phases each 4 cycles.
  - 4-cycle gap with both cs_n high.
  - cs lines never overlap.
- Autonomous polling with SAMPLE_PERIOD=300 and start held 0 -> conversions begin at cycles 299, 599, 899. A start pulse issued mid-conversion is ignored, with no extra sample_valid.
- rst asserted in ROOM_SHIFT after geo=0x20 was shifted -> next cycle cs_n=1, sclk=0, outputs 0, no sample_valid. The next conversion completes normally.
- With SENSOR_PARITY_EN:
  - Geo frame 0x3C with parity 0 is accepted.
  - Corrupted parity on the room frame -> parity_err one pulse, no sample_valid, previous readings retained.
